avg_speed_calc: RTL and testbench
=================================

// Module: avg_speed_calc
// PURPOSE
//  Next-generation bike-computer average-speed unit: avg = trip distance / trip time, in 0.1 km/h.
//  Integrated restoring divider, one quotient bit per clock; no shared external divider.
//  Sits between the distance/time accumulators and the display mux.
//  Start/busy/valid handshake; output saturation; divide-by-zero guard.
// PARAMETERS
//  DIST_W   16   width of trip_distance (centimetres)
//  TIME_W   13   width of trip_time (seconds)
//  OUT_W    10   width of avg_speed
//  MAX_OUT  999  saturation ceiling (99.9 km/h); must be < 2**OUT_W
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous reset, active-high
//  en             in   1       enable; low = FSM and datapath hold state, valid forced 0
//  start          in   1       request new computation (sampled only in IDLE with en=1)
//  unit_mph       in   1       result in 0.1 mph (present only with AVG_SPEED_MPH_EN)
//  trip_distance  in   DIST_W  distance in cm, captured on accepted start
//  trip_time      in   TIME_W  elapsed time in s, captured on accepted start
//  avg_speed      out  OUT_W   result, held until next valid
//  valid          out  1       one-cycle pulse: avg_speed/flags updated
//  busy           out  1       computation in progress
//  saturated      out  1       last result clipped to MAX_OUT
//  div_zero       out  1       last request had trip_time == 0
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, all internal registers 0. Reset mid-operation aborts; no valid.
//  Arithmetic: speed[0.1 km/h] = floor((dist*9) / (time*25)).
//   DVD_W = DIST_W+4 (dividend), DVS_W = TIME_W+5 (divisor); quotient is DVD_W bits, unsigned, exact.
//  FSM: IDLE -> DIV -> FIN -> IDLE.
//   IDLE: busy=0. start=1 & en=1: capture dist*9, time*25; counter=DVD_W; busy<=1; go DIV.
//         If time==0: skip DIV, go FIN with quotient forced 0.
//   DIV: one restoring step per enabled clock (shift remainder, trial subtract, set quotient bit);
//        counter decrements; after DVD_W steps go FIN.
//   FIN: q > MAX_OUT -> avg_speed=MAX_OUT, saturated=1; else avg_speed=q[OUT_W-1:0], saturated=0.
//        div_zero updated; valid<=1 for exactly one cycle; busy<=0 on the same edge; go IDLE.
//  Latency: valid high DVD_W+2 clocks after the edge that accepted start (zero-time case: 2 clocks);
//   en-low cycles add 1:1 and do not advance state.
//  start while busy: ignored, not queued. start held high: new computation accepted the cycle after
//   valid (back-to-back throughput DVD_W+2 clocks).
//  Inputs may change freely after capture; result reflects captured values only.
//  en low during FIN: valid pulse deferred to the first enabled FIN cycle.
//  avg_speed, saturated, div_zero change only on the valid edge.
// CONFIGURATION
//  AVG_SPEED_MPH_EN defined:
//   - unit_mph port exists and is captured with the operands.
//   - If captured unit_mph=1, FIN uses q' = (q*159)>>8 (~0.621 km->mi) before saturation.
//   - FIN takes one extra clock in that case (latency DVD_W+3); km/h latency unchanged.
//  AVG_SPEED_MPH_EN undefined:
//   - No unit_mph port; km/h only; no multiplier logic.
// TESTING (DIST_W=16, TIME_W=13)
//  - dist=50000, time=600, start -> valid after 22 clk; avg_speed=30, saturated=0, div_zero=0.
//  - dist=12345, time=7 -> avg_speed=634; busy high 22 cycles.
//  - dist=65535, time=1 -> avg_speed=999, saturated=1.
//  - time=0, dist=100 -> valid after 2 clk; avg_speed=0, div_zero=1.
//  - Busy/abort: start pulsed mid-DIV -> ignored, single valid. rst asserted mid-DIV -> no valid,
//    all outputs 0. en low 5 cycles mid-DIV -> valid at 27 clk.
//  - MPH_EN, unit_mph=1, dist=50000, time=600 -> avg_speed=18 after 23 clk;
//    unit_mph=0 same values -> 30 after 22 clk.

Source files
------------

// File: rtl/avg_speed_calc.sv
// rtl/avg_speed_calc.sv - trip average speed (0.1 km/h) via bit-serial restoring divider.
// Optional 0.1 mph output selected per request when AVG_SPEED_MPH_EN is defined.
module avg_speed_calc #(
   parameter int DIST_W  = 16,
   parameter int TIME_W  = 13,
   parameter int OUT_W   = 10,
   parameter int MAX_OUT = 999
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic              start_i,
`ifdef AVG_SPEED_MPH_EN
   input  logic              unit_mph_i,
`endif
   input  logic [DIST_W-1:0] trip_distance_i,
   input  logic [TIME_W-1:0] trip_time_i,
   output logic [OUT_W-1:0]  avg_speed_o,
   output logic              valid_o,
   output logic              busy_o,
   output logic              saturated_o,
   output logic              div_zero_o
);

   localparam int DVD_W = DIST_W + 4;
   localparam int DVS_W = TIME_W + 5;
   localparam int CNT_W = $clog2(DVD_W + 1);
   localparam logic [DVD_W-1:0] MAX_Q   = DVD_W'(MAX_OUT);
   localparam logic [OUT_W-1:0] MAX_A   = OUT_W'(MAX_OUT);
   localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(DVD_W);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_MPH, S_FIN} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DVD_W-1:0]  quo_q, quo_d;
   logic [DVS_W-1:0]  rem_q, rem_d;
   logic [DVS_W-1:0]  dvs_q, dvs_d;
   logic              dz_q, dz_d;
   logic              mph_q, mph_d;
   logic [OUT_W-1:0]  avg_q, avg_d;
   logic              sat_q, sat_d;
   logic              dzo_q, dzo_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;

   logic [DVD_W-1:0]  dvd_in;
   logic [DVS_W-1:0]  dvs_in;
   logic [DVS_W:0]    trial;
   logic [DVS_W-1:0]  diff;
   logic              ge;
   logic              mph_in;
   logic [DVD_W-1:0]  mph_val;

   // dist*9 and time*25 as shift-adds; both fit their widths for all inputs
   assign dvd_in = (DVD_W'(trip_distance_i) << 3) + DVD_W'(trip_distance_i);
   assign dvs_in = (DVS_W'(trip_time_i) << 4) + (DVS_W'(trip_time_i) << 3)
                 + DVS_W'(trip_time_i);

   // Quotient bits shift into quo_q from the bottom as dividend bits leave the top
   assign trial = {rem_q, quo_q[DVD_W-1]};
   assign ge    = (trial >= {1'b0, dvs_q});
   assign diff  = trial[DVS_W-1:0] - dvs_q;

`ifdef AVG_SPEED_MPH_EN
   localparam logic [DVD_W+7:0] MPH_K = (DVD_W + 8)'(159);
   assign mph_in  = unit_mph_i;
   assign mph_val = DVD_W'(({8'd0, quo_q} * MPH_K) >> 8);
`else
   assign mph_in  = 1'b0;
   assign mph_val = quo_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      dz_d    = dz_q;
      mph_d   = mph_q;
      avg_d   = avg_q;
      sat_d   = sat_q;
      dzo_d   = dzo_q;
      busy_d  = busy_q;
      valid_d = 1'b0;
      if (en_i) begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  dvs_d  = dvs_in;
                  rem_d  = '0;
                  cnt_d  = CNT_INI;
                  mph_d  = mph_in;
                  busy_d = 1'b1;
                  dz_d   = (trip_time_i == '0);
                  if (trip_time_i == '0) begin
                     quo_d   = '0;
                     state_d = S_FIN;
                  end else begin
                     quo_d   = dvd_in;
                     state_d = S_DIV;
                  end
               end
            end
            S_DIV: begin
               rem_d = ge ? diff : trial[DVS_W-1:0];
               quo_d = {quo_q[DVD_W-2:0], ge};
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d = mph_q ? S_MPH : S_FIN;
               end
            end
            S_MPH: begin
               quo_d   = mph_val;
               state_d = S_FIN;
            end
            S_FIN: begin
               if (quo_q > MAX_Q) begin
                  avg_d = MAX_A;
                  sat_d = 1'b1;
               end else begin
                  avg_d = quo_q[OUT_W-1:0];
                  sat_d = 1'b0;
               end
               dzo_d   = dz_q;
               valid_d = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         dz_q    <= 1'b0;
         mph_q   <= 1'b0;
         avg_q   <= '0;
         sat_q   <= 1'b0;
         dzo_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         dz_q    <= dz_d;
         mph_q   <= mph_d;
         avg_q   <= avg_d;
         sat_q   <= sat_d;
         dzo_q   <= dzo_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign avg_speed_o = avg_q;
   assign valid_o     = valid_q;
   assign busy_o      = busy_q;
   assign saturated_o = sat_q;
   assign div_zero_o  = dzo_q;

endmodule

// File: tb/tb_avg_speed_calc.sv
// tb/tb_avg_speed_calc.sv - randomized and directed bench for avg_speed_calc.
module tb_avg_speed_calc;
   localparam int OUT_W   = 10;
   localparam int MAX_OUT = 999;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_i;
   logic        start_i;
`ifdef AVG_SPEED_MPH_EN
   logic        unit_mph_i;
`endif
   logic [15:0] trip_distance_i;
   logic [12:0] trip_time_i;
   logic [9:0]  avg_speed_o;
   logic        valid_o;
   logic        busy_o;
   logic        saturated_o;
   logic        div_zero_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   avg_speed_calc dut (
      .clk             (clk),
      .rst             (rst),
      .en_i            (en_i),
      .start_i         (start_i),
`ifdef AVG_SPEED_MPH_EN
      .unit_mph_i      (unit_mph_i),
`endif
      .trip_distance_i (trip_distance_i),
      .trip_time_i     (trip_time_i),
      .avg_speed_o     (avg_speed_o),
      .valid_o         (valid_o),
      .busy_o          (busy_o),
      .saturated_o     (saturated_o),
      .div_zero_o      (div_zero_o)
   );

   // Reference: plain integer arithmetic from the unit definition
   function automatic void model(input int unsigned d, input int unsigned t, input bit m,
                                 output int unsigned avg, output bit sat, output bit dz,
                                 output int lat);
      int unsigned q;
      dz  = (t == 0);
      q   = (t == 0) ? 0 : (d * 9) / (t * 25);
      lat = (t == 0) ? 2 : 22;
      if (m && t != 0) begin
         q   = (q * 159) / 256;
         lat = lat + 1;
      end
      sat = (q > MAX_OUT);
      avg = sat ? MAX_OUT : q;
   endfunction

   task automatic set_mph(input bit m);
`ifdef AVG_SPEED_MPH_EN
      unit_mph_i = m;
`else
      if (m) $display("note: mph request ignored in km/h build");
`endif
   endtask

   // Issues one request; lat counts edges from the accepting edge up to the valid edge
   task automatic do_op(input logic [15:0] d, input logic [12:0] t, input bit m,
                        input int en_off_at, output int lat, output logic [9:0] avg,
                        output logic sat, output logic dz, output int busy_bad,
                        output logic valid_after);
      @(negedge clk);
      trip_distance_i = d;
      trip_time_i     = t;
      set_mph(m);
      start_i         = 1'b1;
      @(posedge clk);
      lat      = 1;
      busy_bad = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (i == 0) begin
            start_i         = 1'b0;
            trip_distance_i = 16'($urandom);
            trip_time_i     = 13'($urandom);
         end
         if (valid_o) break;
         if (!busy_o) busy_bad++;
         if (en_off_at >= 0) en_i = !(i >= en_off_at && i < en_off_at + 5);
         lat++;
      end
      en_i = 1'b1;
      if (busy_o) busy_bad++;
      avg = avg_speed_o;
      sat = saturated_o;
      dz  = div_zero_o;
      @(negedge clk);
      valid_after = valid_o;
   endtask

   task automatic run_and_check(input string name, input logic [15:0] d,
                                input logic [12:0] t, input bit m, input int en_off_at);
      int          lat, e_lat, busy_bad;
      int unsigned e_avg;
      bit          e_sat, e_dz;
      logic [9:0]  avg;
      logic        sat, dz, v2;
      model(d, t, m, e_avg, e_sat, e_dz, e_lat);
      if (en_off_at >= 0) e_lat = e_lat + 5;
      do_op(d, t, m, en_off_at, lat, avg, sat, dz, busy_bad, v2);
      checks++;
      if (lat !== e_lat) begin
         failures++;
         $display("FAIL %s latency d=%0d t=%0d got=%0d exp=%0d", name, d, t, lat, e_lat);
      end
      checks++;
      if (avg !== OUT_W'(e_avg) || sat !== e_sat || dz !== e_dz) begin
         failures++;
         $display("FAIL %s result d=%0d t=%0d m=%0d got avg=%0d sat=%0d dz=%0d exp avg=%0d sat=%0d dz=%0d",
                  name, d, t, m, avg, sat, dz, e_avg, e_sat, e_dz);
      end
      checks++;
      if (busy_bad !== 0 || v2 !== 1'b0) begin
         failures++;
         $display("FAIL %s handshake busy_errs=%0d valid_second_cycle=%0d exp 0/0",
                  name, busy_bad, v2);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en_i = 1'b1; start_i = 1'b0;
      trip_distance_i = '0; trip_time_i = '0;
      set_mph(1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({avg_speed_o, valid_o, busy_o, saturated_o, div_zero_o} !== 14'd0) begin
         failures++;
         $display("FAIL reset outputs got=%h exp=0",
                  {avg_speed_o, valid_o, busy_o, saturated_o, div_zero_o});
      end
   endtask

   task automatic test_directed();
      run_and_check("spec_30",   16'd50000, 13'd600, 1'b0, -1);
      run_and_check("spec_634",  16'd12345, 13'd7,   1'b0, -1);
      run_and_check("spec_sat",  16'd65535, 13'd1,   1'b0, -1);
      run_and_check("spec_zero", 16'd100,   13'd0,   1'b0, -1);
      run_and_check("edge_999",  16'd2775,  13'd1,   1'b0, -1);
      run_and_check("edge_1000", 16'd2778,  13'd1,   1'b0, -1);
      run_and_check("zero_dist", 16'd0,     13'd8191, 1'b0, -1);
   endtask

   task automatic test_random();
      logic [15:0] d;
      logic [12:0] t;
      bit          m;
      for (int k = 0; k < 24; k++) begin
         d = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       t = 13'd0;
            1:       t = 13'($urandom_range(1, 20));
            default: t = 13'($urandom_range(1, 8191));
         endcase
`ifdef AVG_SPEED_MPH_EN
         m = 1'($urandom);
`else
         m = 1'b0;
`endif
         run_and_check("random", d, t, m, -1);
      end
   endtask

   task automatic test_en_hold();
      run_and_check("en_low5", 16'd50000, 13'd600, 1'b0, 5);
   endtask

   task automatic test_start_while_busy();
      int nvalid = 0;
      logic [9:0] first_avg = '0;
      @(negedge clk);
      trip_distance_i = 16'd50000; trip_time_i = 13'd600; set_mph(1'b0); start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i == 5) begin
            trip_distance_i = 16'd65535; trip_time_i = 13'd1; start_i = 1'b1;
         end
         if (i == 6) start_i = 1'b0;
         if (valid_o) begin
            nvalid++;
            first_avg = avg_speed_o;
         end
         @(negedge clk);
      end
      checks++;
      if (nvalid !== 1 || first_avg !== 10'd30) begin
         failures++;
         $display("FAIL busy_start got valids=%0d avg=%0d exp valids=1 avg=30", nvalid, first_avg);
      end
   endtask

   task automatic test_abort();
      int nvalid = 0;
      @(negedge clk);
      trip_distance_i = 16'd65535; trip_time_i = 13'd1; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({avg_speed_o, valid_o, busy_o, saturated_o, div_zero_o} !== 14'd0) begin
         failures++;
         $display("FAIL abort_outputs got=%h exp=0",
                  {avg_speed_o, valid_o, busy_o, saturated_o, div_zero_o});
      end
      for (int i = 0; i < 40; i++) begin
         if (valid_o || busy_o) nvalid++;
         @(negedge clk);
      end
      checks++;
      if (nvalid !== 0) begin
         failures++;
         $display("FAIL abort_no_valid got active_cycles=%0d exp=0", nvalid);
      end
   endtask

   task automatic test_back_to_back();
      int          e = 1;
      int          nv = 0;
      int          vidx[2];
      logic [9:0]  vavg[2];
      int unsigned ea, eb;
      bit          s, z;
      int          l;
      model(50000, 600, 1'b0, ea, s, z, l);
      model(12345, 7,   1'b0, eb, s, z, l);
      @(negedge clk);
      trip_distance_i = 16'd50000; trip_time_i = 13'd600; set_mph(1'b0); start_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      trip_distance_i = 16'd12345; trip_time_i = 13'd7;
      for (int i = 0; i < 100 && nv < 2; i++) begin
         if (valid_o) begin
            vidx[nv] = e;
            vavg[nv] = avg_speed_o;
            nv++;
            if (nv == 2) start_i = 1'b0;
         end
         if (nv < 2) begin
            e++;
            @(negedge clk);
         end
      end
      start_i = 1'b0;
      checks++;
      if (nv !== 2 || vidx[0] !== 22 || vidx[1] !== 44) begin
         failures++;
         $display("FAIL b2b_timing got valids=%0d at %0d,%0d exp 2 at 22,44", nv, vidx[0], vidx[1]);
      end
      checks++;
      if (vavg[0] !== OUT_W'(ea) || vavg[1] !== OUT_W'(eb)) begin
         failures++;
         $display("FAIL b2b_results got=%0d,%0d exp=%0d,%0d", vavg[0], vavg[1], ea, eb);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle busy got=%0d exp=0", busy_o);
      end
   endtask

`ifdef AVG_SPEED_MPH_EN
   task automatic test_mph();
      run_and_check("mph_18", 16'd50000, 13'd600, 1'b1, -1);
      run_and_check("kmh_30", 16'd50000, 13'd600, 1'b0, -1);
      run_and_check("mph_sat", 16'd65535, 13'd1,  1'b1, -1);
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_en_hold();
      test_start_while_busy();
      test_abort();
      test_back_to_back();
`ifdef AVG_SPEED_MPH_EN
      test_mph();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end
endmodule
